// File: rtl/req_ack_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter (master), its requesters
// and the shared req/ack/enable target (slave side driven by the environment).
interface req_ack_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] src_req;
  logic [N_REQ-1:0] src_grant;
  logic [N_REQ-1:0] src_done;
  logic [N_REQ-1:0] src_err;
  logic             req;
  logic             ack;
  logic             enable;
  logic             busy;
  logic             err_sticky;
  logic             clr_err;

  modport master (
    input  src_req, ack, clr_err,
    output src_grant, src_done, src_err, req, enable, busy, err_sticky
  );

  modport slave (
    output src_req, ack, clr_err,
    input  src_grant, src_done, src_err, req, enable, busy, err_sticky
  );
endinterface

// File: rtl/req_ack_rr_arbiter.sv
// Round-robin arbiter sharing one req/ack/enable target among N_REQ requesters,
// with per-edge ack timeouts, spurious-ack detection and a sticky error flag.
module req_ack_rr_arbiter #(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  req_ack_rr_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] winner, winner_nxt;
  logic [IDX_W-1:0] pick;
  logic [SUM_W-1:0] slot;
  logic             failed, failed_nxt;
  logic [N_REQ-1:0] grant, grant_nxt;
  logic [N_REQ-1:0] done, done_nxt;
  logic [N_REQ-1:0] err, err_nxt;
  logic             tgt_req, tgt_req_nxt;
  logic             tgt_en, tgt_en_nxt;
  logic             busy, busy_nxt;
  logic             sticky, sticky_nxt;
  logic             cnt_max;
  logic             err_set;

  assign cnt_max = (cnt == CNT_W'(TIMEOUT - 1));

  // Scan downward so the lowest offset from ptr is the last, winning hit.
  always_comb begin
    pick = '0;
    slot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      slot = SUM_W'(ptr) + SUM_W'(i);
      if (slot >= SUM_W'(N_REQ)) slot = slot - SUM_W'(N_REQ);
      if (bus.src_req[slot[IDX_W-1:0]]) pick = slot[IDX_W-1:0];
    end
  end

  // State register plus every registered output; nothing reaches a port combinationally.
  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      winner  <= '0;
      failed  <= 1'b0;
      grant   <= '0;
      done    <= '0;
      err     <= '0;
      tgt_req <= 1'b0;
      tgt_en  <= 1'b0;
      busy    <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      winner  <= winner_nxt;
      failed  <= failed_nxt;
      grant   <= grant_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      tgt_req <= tgt_req_nxt;
      tgt_en  <= tgt_en_nxt;
      busy    <= busy_nxt;
      sticky  <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|bus.src_req)          state_nxt = REQ;
      REQ:     if (bus.ack || cnt_max)    state_nxt = REL;
      REL:     if (!bus.ack || cnt_max)   state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_nxt     = cnt + 1'b1;
    ptr_nxt     = ptr;
    winner_nxt  = winner;
    failed_nxt  = failed;
    grant_nxt   = grant;
    done_nxt    = '0;
    err_nxt     = '0;
    tgt_req_nxt = tgt_req;
    tgt_en_nxt  = tgt_en;
    busy_nxt    = busy;
    err_set     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        err_set = bus.ack;  // no owner, so only the sticky flag records it
        if (|bus.src_req) begin
          winner_nxt  = pick;
          grant_nxt   = N_REQ'(1) << pick;
          failed_nxt  = 1'b0;
          tgt_req_nxt = 1'b1;
          tgt_en_nxt  = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      REQ: begin
        if (bus.ack) begin
          cnt_nxt     = '0;
          tgt_req_nxt = 1'b0;
        end else if (cnt_max) begin
          cnt_nxt     = '0;
          tgt_req_nxt = 1'b0;
          failed_nxt  = 1'b1;
          err_nxt     = grant;
          err_set     = 1'b1;
        end
      end
      REL: begin
        if (!bus.ack || cnt_max) begin
          cnt_nxt    = '0;
          grant_nxt  = '0;
          tgt_en_nxt = 1'b0;
          busy_nxt   = 1'b0;
          ptr_nxt    = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          if (!bus.ack) begin
            done_nxt = failed ? '0 : grant;
          end else begin
            // A request timeout already pulsed src_err for this owner.
            err_nxt = failed ? '0 : grant;
            err_set = 1'b1;
          end
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase

    if (err_set)          sticky_nxt = 1'b1;
    else if (bus.clr_err) sticky_nxt = 1'b0;
    else                  sticky_nxt = sticky;
  end

  assign bus.src_grant  = grant;
  assign bus.src_done   = done;
  assign bus.src_err    = err;
  assign bus.req        = tgt_req;
  assign bus.enable     = tgt_en;
  assign bus.busy       = busy;
  assign bus.err_sticky = sticky;

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
// Self-checking bench for req_ack_rr_arbiter: a target model drives ack and a
// scoreboard of expected completions is matched against done/err pulses.
module tb_req_ack_rr_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  typedef enum int {T_NORMAL, T_SILENT, T_STUCK, T_MANUAL} tmode_t;

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [N-1:0] err;
  } exp_t;

  logic   clk;
  logic   rst_n;
  tmode_t tmode;
  logic   ack_tgt;
  logic   ack_man;
  logic   req_prev;
  logic [N-1:0] last_grant;
  exp_t   sb[$];
  int     checks;
  int     errors;

  req_ack_rr_arbiter_if #(.N_REQ(N)) bus ();

  req_ack_rr_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.ack = (tmode == T_MANUAL) ? ack_man : ack_tgt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [N-1:0] g, input logic [N-1:0] d, input logic [N-1:0] e);
    exp_t x;
    x.grant = g;
    x.done  = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Raise the requests, wait for the grant, then withdraw them.
  task automatic start(input logic [N-1:0] r);
    int n;
    bus.src_req = r;
    n = 0;
    cyc(1);
    while (bus.src_grant == '0 && n < 10) begin
      n++;
      cyc(1);
    end
    if (bus.src_grant == '0) check("grant_wait_timeout", 32'(bus.src_grant), 32'(r));
    bus.src_req = '0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      n++;
      cyc(1);
    end
    check(tag, 32'(sb.size()), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  // Target: acks as soon as req is seen, releases one cycle after req falls.
  initial begin
    ack_tgt  = 1'b0;
    req_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      unique case (tmode)
        T_NORMAL: ack_tgt = bus.req | req_prev;
        T_SILENT: ack_tgt = 1'b0;
        T_STUCK:  ack_tgt = bus.busy & (ack_tgt | bus.req);
        default:  ack_tgt = 1'b0;
      endcase
      req_prev = bus.req;
    end
  end

  // Monitor: completions against the scoreboard, plus invariants every cycle.
  initial begin
    exp_t e;
    last_grant = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.src_grant != '0) last_grant = bus.src_grant;
      if ((bus.src_done | bus.src_err) != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'({bus.src_done, bus.src_err}), 0);
        end else begin
          e = sb.pop_front();
          check("sb_grant", 32'(last_grant), 32'(e.grant));
          check("sb_done", 32'(bus.src_done), 32'(e.done));
          check("sb_err", 32'(bus.src_err), 32'(e.err));
        end
      end
      check("inv_onehot", 32'($onehot0(bus.src_grant)), 1);
      check("inv_done_err", 32'(|(bus.src_done & bus.src_err)), 0);
      check("inv_req_enable", 32'(bus.req & ~bus.enable), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    tmode       = T_NORMAL;
    ack_man     = 1'b0;
    rst_n       = 1'b0;
    bus.src_req = '0;
    bus.clr_err = 1'b0;
    cyc(2);
    check("reset_outputs", 32'({bus.src_grant, bus.src_done, bus.src_err,
          bus.req, bus.enable, bus.busy, bus.err_sticky}), 0);
    rst_n = 1'b1;
    cyc(1);

    // Single requester, minimum-length transaction.
    push(4'b0010, 4'b0010, 4'b0000);
    bus.src_req = 4'b0010;
    cyc(1);
    check("single_grant", 32'(bus.src_grant), 32'(4'b0010));
    check("single_req", 32'(bus.req), 1);
    bus.src_req = '0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      cyc(1);
    end
    check("single_busy_cycles", 32'(n), 3);
    wait_done("single_complete");

    // Round robin from a fresh reset, wrapping back to requester 0.
    pulse_reset();
    push(4'b0001, 4'b0001, 4'b0000);
    push(4'b0010, 4'b0010, 4'b0000);
    push(4'b0100, 4'b0100, 4'b0000);
    push(4'b1000, 4'b1000, 4'b0000);
    push(4'b0001, 4'b0001, 4'b0000);
    bus.src_req = 4'b1111;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      cyc(1);
    end
    bus.src_req = '0;
    wait_done("rr_complete");

    // Request timeout: ack never rises.
    pulse_reset();
    tmode = T_SILENT;
    push(4'b0100, 4'b0000, 4'b0100);
    start(4'b0100);
    n = 0;
    while (bus.req && n < 64) begin
      n++;
      cyc(1);
    end
    check("req_timeout_len", 32'(n), TO);
    check("req_timeout_sticky", 32'(bus.err_sticky), 1);
    wait_done("req_timeout_complete");
    tmode = T_NORMAL;
    push(4'b1000, 4'b1000, 4'b0000);
    start(4'b1100);
    wait_done("ptr_advance_complete");
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    check("clear_after_timeout", 32'(bus.err_sticky), 0);

    // Release timeout: ack stays high after the handshake.
    tmode = T_STUCK;
    push(4'b0001, 4'b0000, 4'b0001);
    start(4'b0001);
    n = 0;
    while (bus.req && n < 10) begin
      n++;
      cyc(1);
    end
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      cyc(1);
    end
    check("rel_timeout_len", 32'(n), TO);
    check("rel_timeout_sticky", 32'(bus.err_sticky), 1);
    wait_done("rel_timeout_complete");
    tmode = T_NORMAL;
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    check("clear_after_rel", 32'(bus.err_sticky), 0);

    // Spurious ack in IDLE, clear, and set-beats-clear.
    tmode   = T_MANUAL;
    ack_man = 1'b1;
    cyc(1);
    ack_man = 1'b0;
    check("spurious_sticky", 32'(bus.err_sticky), 1);
    check("spurious_no_err", 32'(bus.src_err), 0);
    bus.clr_err = 1'b1;
    cyc(1);
    check("spurious_clear", 32'(bus.err_sticky), 0);
    ack_man = 1'b1;
    cyc(1);
    ack_man = 1'b0;
    check("set_beats_clear", 32'(bus.err_sticky), 1);
    cyc(1);
    bus.clr_err = 1'b0;
    check("final_clear", 32'(bus.err_sticky), 0);
    tmode = T_NORMAL;
    cyc(1);

    // Reset in the middle of REQ aborts without pulses and resets the pointer.
    tmode = T_SILENT;
    start(4'b0010);
    cyc(3);
    check("midreq_req_high", 32'(bus.req), 1);
    rst_n = 1'b0;
    cyc(1);
    check("midreq_reset_outputs", 32'({bus.src_grant, bus.src_done, bus.src_err,
          bus.req, bus.enable, bus.busy, bus.err_sticky}), 0);
    rst_n = 1'b1;
    tmode = T_NORMAL;
    cyc(1);
    push(4'b0001, 4'b0001, 4'b0000);
    start(4'b1111);
    wait_done("post_reset_complete");

    cyc(2);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_ack_rr_arbiter.md
Name: req_ack_rr_arbiter

Overview:
- Shares one req/ack/enable handshake target among N_REQ requesters using round-robin arbitration.
- Per transaction: grants one requester, raises req and enable, waits for ack, drops req, waits for ack release, then reports completion.
- Timeout and spurious-ack detection produce error pulses and a sticky error flag.
- Sits between requesting agents and the shared handshake target. Its req/ack/enable outputs are the signals checked by the team's handshake assertion module.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT, 16, maximum cycles to wait for each ack edge (>=2).
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, do not override).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst_n, input, 1: synchronous active-low reset.
- src_req, input, N_REQ: level request per requester.
- src_grant, output, N_REQ: one-hot grant, held for the whole transaction.
- src_done, output, N_REQ: one-cycle pulse to the winner on successful completion.
- src_err, output, N_REQ: one-cycle pulse to the winner on timeout.
- req, output, 1: request to target.
- ack, input, 1: acknowledge from target.
- enable, output, 1: target enable; high from grant until the transaction ends.
- busy, output, 1: high in any state other than IDLE.
- err_sticky, output, 1: set by any timeout or spurious ack.
- clr_err, input, 1: clears err_sticky.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE.
  - All outputs 0.
  - Counter 0.
  - Round-robin pointer = 0, so requester 0 has highest priority after reset.
  - Reset mid-transaction aborts immediately. No done or err pulse is issued.
- States: IDLE, REQ, REL.
- IDLE:
  - If src_req != 0 at posedge t, the winner is the first set bit scanning from ptr upward, with wrap-around.
  - At t+1: state=REQ, src_grant=onehot(winner), req=1, enable=1, busy=1, counter=0.
- REQ:
  - The counter increments each cycle.
  - If ack=1: next cycle state=REL, req=0; enable stays 1.
  - Else if the counter reaches TIMEOUT-1: next cycle state=REL, req=0, src_err[winner] pulses, err_sticky=1, and the transaction is flagged failed.
  - On entry to REL the counter resets to 0.
- REL:
  - req=0, enable=1.
  - If ack=0: next cycle state=IDLE; grant, enable and busy drop to 0; ptr=(winner+1) mod N_REQ.
  - On that same cycle, src_done[winner] pulses only if the transaction did not fail.
  - If ack is still 1 when the counter reaches TIMEOUT-1: exit to IDLE, pulse src_err (not done), set err_sticky.
  - At most one src_err pulse per transaction.
- Throughput:
  - Minimum transaction is 3 busy cycles when ack responds in one cycle and releases in one cycle.
  - At least one IDLE cycle occurs between transactions.
- Outputs: all registered; no combinational path from src_req or ack to any output.
- src_req changes after grant are ignored; the transaction always completes or times out.
- Spurious ack: ack=1 while in IDLE sets err_sticky. No src_err pulse, since there is no owner.
- err_sticky priority: set beats clr_err in the same cycle; otherwise clr_err=1 clears it next cycle.
- Invariants (assertion-checkable):
  - src_grant is one-hot or zero.
  - src_done and src_err are never both high.
  - req implies enable.
  - $rose(req) implies src_grant != 0.

Test Plan:
- Single requester: src_req=4'b0010 held, target acks 1 cycle after req and releases 1 cycle after req falls → grant=0010 and req rise 1 cycle after src_req; src_done[1] pulses once; busy for exactly 3 cycles.
- Round-robin: src_req=4'b1111 held for 4 transactions after reset → grant order 0001, 0010, 0100, 1000, then wraps to 0001.
- Request timeout: TIMEOUT=16, ack never rises → req high for 16 cycles then falls; src_err[winner] pulses; err_sticky=1; no src_done; ptr advances.
- Release timeout: ack stuck high after the handshake → exit after TIMEOUT cycles in REL with src_err pulse and err_sticky=1.
- Spurious ack plus clear:
  - ack=1 in IDLE → err_sticky=1 next cycle, src_err stays 0.
  - clr_err=1 with no new error → err_sticky=0 next cycle.
  - clr_err together with a spurious ack → err_sticky stays 1.
- Reset mid-REQ: rst_n=0 for 1 cycle while req=1 → next cycle all outputs 0, no pulses; next arbitration starts from requester 0.
